// File: rtl/boot_loader.sv
// boot_loader: boot-time ROM -> RAM copy sequencer.
// Sweeps the byte address space one word per cycle. The ROM drives the shared
// bus and the RAM captures it. The CPU is held in reset-hold until the image
// is resident.
// Build macro BOOT_VERIFY_EN adds a read-back pass that compares a checksum of
// the written words with a checksum of the RAM contents and flags `error`.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module boot_loader #(
  parameter int ADDR_W     = `ADDR_SIZE,
  parameter int DATA_W     = `WORD_SIZE,
  parameter int STEP       = 2,
  parameter int LOAD_BYTES = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              rom_oe,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              error
);

  // Address of the final word of the image; reaching it ends a sweep, so the
  // address register never wraps during a sweep.
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_BYTES - STEP);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              wr_en_nxt;
  logic              rom_oe_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              cpu_hold_nxt;
  logic              last_word;

  // Byte address advance; wraps modulo 2**ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_STEP;
  endfunction

  assign last_word = (addr == LAST_ADDR);

`ifdef BOOT_VERIFY_EN
  logic [DATA_W-1:0] sum_w;
  logic [DATA_W-1:0] sum_r;
  logic [DATA_W-1:0] sum_w_nxt;
  logic [DATA_W-1:0] sum_r_nxt;
  logic              error_q;
  logic              error_nxt;

  // Modular (wrap-around) checksum accumulate, DATA_W bits wide.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] d);
    return s + d;
  endfunction

  assign error = error_q;
`else
  // Bus sample is only consumed by the verify checksums.
  logic unused_data;
  assign unused_data = ^data_in;
  assign error       = 1'b0;
`endif

  // Next-state and next-output logic; every register holds unless a state acts.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    wr_en_nxt    = wr_en;
    rom_oe_nxt   = rom_oe;
    busy_nxt     = busy;
    done_nxt     = done;
    cpu_hold_nxt = cpu_hold;
`ifdef BOOT_VERIFY_EN
    sum_w_nxt    = sum_w;
    sum_r_nxt    = sum_r;
    error_nxt    = error_q;
`endif
    case (state)
      IDLE, DONE: begin
        // A start request (first run or re-run) begins a fresh load.
        if (start) begin
          state_nxt    = LOAD;
          addr_nxt     = '0;
          wr_en_nxt    = 1'b1;
          rom_oe_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          cpu_hold_nxt = 1'b1;
`ifdef BOOT_VERIFY_EN
          sum_w_nxt    = '0;
          sum_r_nxt    = '0;
          error_nxt    = 1'b0;
`endif
        end
      end
      LOAD: begin
        // The RAM captures the word on this edge; start is ignored here.
`ifdef BOOT_VERIFY_EN
        sum_w_nxt = csum_add(sum_w, data_in);
`endif
        if (last_word) begin
          addr_nxt   = '0;
          wr_en_nxt  = 1'b0;
          rom_oe_nxt = 1'b0;
`ifdef BOOT_VERIFY_EN
          state_nxt  = VERIFY;
`else
          state_nxt    = DONE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          cpu_hold_nxt = 1'b0;
`endif
        end else begin
          addr_nxt = addr_inc(addr);
        end
      end
`ifdef BOOT_VERIFY_EN
      VERIFY: begin
        // The RAM drives the bus by asynchronous read while the ROM stays off.
        sum_r_nxt = csum_add(sum_r, data_in);
        if (last_word) begin
          addr_nxt  = '0;
          state_nxt = CHECK;
        end else begin
          addr_nxt = addr_inc(addr);
        end
      end
      CHECK: begin
        // Release the CPU regardless of the outcome; error is reported alongside.
        state_nxt    = DONE;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b1;
        cpu_hold_nxt = 1'b0;
        error_nxt    = (sum_w != sum_r);
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset has priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      wr_en    <= 1'b0;
      rom_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
`ifdef BOOT_VERIFY_EN
      sum_w    <= '0;
      sum_r    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      wr_en    <= wr_en_nxt;
      rom_oe   <= rom_oe_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      cpu_hold <= cpu_hold_nxt;
`ifdef BOOT_VERIFY_EN
      sum_w    <= sum_w_nxt;
      sum_r    <= sum_r_nxt;
      error_q  <= error_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: scoreboard bench for boot_loader with ROM/RAM bus models.
// Expected writes and done events are queued when a start is accepted by the
// reference model; a negedge monitor pops and compares as the DUT produces them.
`timescale 1ns/1ps

module tb_boot_loader;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int STEP       = 2;
  localparam int LOAD_BYTES = 256;
  localparam int NWORDS     = LOAD_BYTES / STEP;
`ifdef BOOT_VERIFY_EN
  localparam int LAT = 2 * NWORDS + 2;
`else
  localparam int LAT = NWORDS + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic              wr_en, rom_oe, busy, done, cpu_hold, error;

  boot_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STEP(STEP), .LOAD_BYTES(LOAD_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .addr(addr), .wr_en(wr_en), .rom_oe(rom_oe), .busy(busy),
    .done(done), .cpu_hold(cpu_hold), .error(error)
  );

  always #5 clk = ~clk;

  // Memory models: byte-addressed ROM and RAM sharing one 16-bit bus.
  logic [7:0]        rom [LOAD_BYTES];
  logic [7:0]        ram [LOAD_BYTES];
  logic              inject = 1'b0;
  logic              flip;
  logic [DATA_W-1:0] bus;

  always_comb begin
    if (rom_oe) bus = {rom[int'(addr) + 1], rom[int'(addr)]};
    else        bus = {ram[int'(addr) + 1], ram[int'(addr)]};
    flip    = inject && busy && !wr_en && !rom_oe && (addr == 8'd10);
    data_in = bus ^ {{(DATA_W-1){1'b0}}, flip};
  end

  always @(posedge clk) begin
    if (wr_en) begin
      ram[int'(addr)]     <= data_in[7:0];
      ram[int'(addr) + 1] <= data_in[15:8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct { int c; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { int c; logic err; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  int  model_free = 0;

  // Monitor: flag consistency every cycle, write and done events vs scoreboard.
  logic prev_done = 1'b0;
  wr_t  w_cur;
  dn_t  d_cur;
  always @(negedge clk) begin
    chk("flag_consistency",
        ({busy, done, cpu_hold} == 3'b101) || ({busy, done, cpu_hold} == 3'b010) ||
        ({busy, done, cpu_hold} == 3'b001), 1);
    if (wr_en) begin
      if (wr_q.size() == 0) fail_now("unexpected_write");
      else begin
        w_cur = wr_q.pop_front();
        chk("write_cycle", cyc, w_cur.c);
        chk("write_addr", addr, w_cur.a);
        chk("write_data", data_in, w_cur.d);
        chk("write_rom_oe", rom_oe, 1);
      end
    end
    if (done && !prev_done) begin
      if (dn_q.size() == 0) fail_now("unexpected_done");
      else begin
        d_cur = dn_q.pop_front();
        chk("done_cycle", cyc, d_cur.c);
        chk("error_at_done", error, d_cur.err);
        chk("hold_released_at_done", cpu_hold, 0);
      end
    end
    prev_done <= done;
  end

  // Start request held for `hold` edges; the model accepts it only when idle/done.
  task automatic issue_start(input int hold, input logic err_exp);
    int e;
    wr_t w;
    dn_t d;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #2;
      start = 1'b1;
      e = cyc + 1;
      if (e >= model_free) begin
        for (int j = 0; j < NWORDS; j++) begin
          w.c = e + j;
          w.a = ADDR_W'(j * STEP);
          w.d = {rom[j * STEP + 1], rom[j * STEP]};
          wr_q.push_back(w);
        end
        d.c = e + LAT - 1;
        d.err = err_exp;
        dn_q.push_back(d);
        model_free = e + LAT;
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (cyc < model_free + 1 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk("done_level", done, 1);
    chk("hold_low_in_done", cpu_hold, 0);
    chk("busy_low_in_done", busy, 0);
    chk("addr_zero_in_done", addr, 0);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("done_queue_drained", dn_q.size(), 0);
  endtask

  task automatic ram_check(input string name, input int lo, input int hi);
    int bad = 0;
    for (int k = lo; k <= hi; k++) if (ram[k] != rom[k]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rom_oe"}, rom_oe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic new_rom();
    for (int k = 0; k < LOAD_BYTES; k++) rom[k] = 8'($urandom);
  endtask

  task automatic abort_at(input int where);
    int guard = 0;
    while (!(wr_en && addr == ADDR_W'(where)) && guard < 400) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("abort_point_reached", addr, where);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    wr_q.delete();
    dn_q.delete();
    model_free = cyc + 1;
    @(negedge clk);
    reset_outs("abort");
    ram_check("ram_partial_image", 0, where - 1);
  endtask

  initial begin
    for (int k = 0; k < LOAD_BYTES; k++) rom[k] = 8'(k);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    model_free = cyc + 1;
    @(negedge clk);
    reset_outs("reset");

    // Counting image, single-cycle start.
    issue_start(1, 1'b0);
    wait_done();
    ram_check("ram_counting_image", 0, LOAD_BYTES - 1);

    // Start held for 10 cycles: one sweep only.
    new_rom();
    issue_start(10, 1'b0);
    wait_done();
    ram_check("ram_after_held_start", 0, LOAD_BYTES - 1);

    // Reset at addr 64, then full reload.
    new_rom();
    issue_start(1, 1'b0);
    abort_at(64);
    issue_start(1, 1'b0);
    wait_done();
    ram_check("ram_after_abort_reload", 0, LOAD_BYTES - 1);

    // Random abort point, reload with random start width.
    new_rom();
    issue_start(1, 1'b0);
    abort_at(2 * $urandom_range(1, NWORDS - 2));
    issue_start($urandom_range(1, 10), 1'b0);
    wait_done();
    ram_check("ram_after_random_abort", 0, LOAD_BYTES - 1);

`ifdef BOOT_VERIFY_EN
    // Corrupted read-back at address 10: error reported with done.
    new_rom();
    inject = 1'b1;
    issue_start(1, 1'b1);
    wait_done();
    inject = 1'b0;
    chk("error_sticky_in_done", error, 1);
`endif

    // Re-run from DONE: done drops and hold rises on the start edge.
    new_rom();
    issue_start(1, 1'b0);
    @(negedge clk);
    chk("rerun_done_cleared", done, 0);
    chk("rerun_hold_set", cpu_hold, 1);
    chk("rerun_busy_set", busy, 1);
    chk("rerun_error_cleared", error, 0);
    wait_done();
    ram_check("ram_after_rerun", 0, LOAD_BYTES - 1);

    // A few randomized runs with random gaps and start widths.
    for (int r = 0; r < 3; r++) begin
      new_rom();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      issue_start($urandom_range(1, 10), 1'b0);
      wait_done();
      ram_check("ram_random_run", 0, LOAD_BYTES - 1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
